switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Conditions the raw mechanical switch bank before it reaches the bussed switch input stage.
- Provides a 2-FF synchroniser and a per-bit persistence-counter debouncer.
- Adds change detection: a one-cycle event pulse plus a sticky per-bit change mask that the bus master can acknowledge.
- sw_out keeps raw polarity (pull-up idle = 1) and wires directly to the downstream stage's in_sw, which performs the inversion.

Parameters:
- WIDTH, 8: number of switch bits.
- CNT_MAX, 50000: consecutive mismatching cycles required to accept a new level (1 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 16: width of each per-bit counter.
- RESET_VAL, 8'hFF: reset level of the synchronisers and sw_out (all switches released).

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- raw_sw, input, WIDTH: asynchronous raw switch pins.
- clr, input, 1: acknowledge; clears change_mask bits on the next edge.
- sw_out, output, WIDTH: debounced level to the switch bus stage (in_sw).
- changed, output, 1: one-cycle pulse when any sw_out bit updates.
- change_mask, output, WIDTH: sticky record of which bits have updated since the last clr.

Behaviour:
- Reset (reset=1 sampled at an edge), taking priority over everything else:
  - sync1 = sync2 = RESET_VAL
  - sw_out = RESET_VAL
  - all counters = 0
  - changed = 0, change_mask = 0
- Reset mid-count discards partial counts. Nothing is pending after reset is released.
- Synchroniser: each edge, sync1 <= raw_sw and sync2 <= sync1. Only sync2 is used downstream.
- Per-bit debounce, with mismatch = (sync2[i] != sw_out[i]):
  - No mismatch: cnt[i] <= 0.
  - Mismatch and cnt[i] < CNT_MAX-1: cnt[i] <= cnt[i]+1.
  - Mismatch and cnt[i] == CNT_MAX-1: sw_out[i] <= sync2[i], cnt[i] <= 0, and the bit is flagged as updating this edge.
- Latency:
  - Let k be the edge at which sync1 first captures a new stable level.
  - sw_out changes on edge k+CNT_MAX+1.
  - With raw_sw changing between edges, sw_out therefore updates CNT_MAX+1 edges after the first sampling edge.
- Glitch rejection: any reversion of sync2 to the sw_out level before the count completes clears cnt[i]. Pulses shorter than CNT_MAX cycles never reach sw_out.
- Bits are fully independent; several bits may update on the same edge.
- changed:
  - Registered; it is 1 during exactly the cycle in which sw_out first shows the new value(s), and 0 otherwise.
  - It is one pulse per update edge, even if several bits update on that edge.
- change_mask[i]:
  - Set on the edge at which bit i updates.
  - Cleared on an edge where clr=1.
  - If set and clr occur on the same edge for bit i, set wins (the bit stays 1). Other bits clear normally.
- clr has no effect on sw_out, the counters or changed.
- Counters never exceed CNT_MAX-1, so no wrap-around is possible.
- No combinational path from any input to any output; all outputs are registered.

Test Plan (CNT_MAX=4, WIDTH=8, RESET_VAL=8'hFF):
1. Reset: assert reset for 2 cycles with raw_sw=8'h00 -> sw_out=8'hFF, changed=0, change_mask=8'h00 during reset and on the first cycle after release.
2. Clean press: raw_sw 8'hFF -> 8'hFE, held; with k the first capturing edge -> sw_out=8'hFE after edge k+5, changed=1 for exactly that one cycle, change_mask=8'h01.
3. Glitch rejection: raw_sw[3]=0 for 3 cycles, then back to 1 -> sw_out and change_mask unchanged, changed never asserts. Repeat with 4-cycle low after sync delay -> bit 3 does update.
4. Simultaneous bits: raw_sw 8'hFF -> 8'h5A in one step -> all changing bits update on the same edge, sw_out=8'h5A, a single 1-cycle changed pulse, change_mask=8'hA5.
5. clr vs set collision: with change_mask=8'h01, assert clr on the same edge bit 7 updates -> change_mask=8'h80. Then clr alone -> 8'h00.
6. Reset mid-count: raw_sw[0]=0, assert reset after 2 counted cycles, release with raw_sw[0] still 0 -> sw_out[0] stays 1 until a full 4-cycle count completes after release (edge k'+5 from the new capture).

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises and debounces a raw switch bank, reporting level changes.
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   raw_sw      asynchronous raw switch pins (pull-up idle = 1)
//   clr         acknowledge, clears change_mask bits on the next edge
//   sw_out      debounced level, raw polarity
//   changed     one-cycle pulse on any sw_out update
//   change_mask sticky per-bit record of updates since the last clr
module switch_debouncer #(
  parameter int WIDTH = 8,
  parameter int CNT_MAX = 50000,
  parameter int CNT_W = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_sw,
  input  logic             clr,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic [WIDTH-1:0] change_mask
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, sw_q, sw_d, upd, mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic changed_q;
  always_comb begin
    upd = '0;
    sw_d = sw_q;
    cnt_d = '{default: '0};
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (sync2_q[i] != sw_q[i]) && (cnt_q[i] == LAST);
      // A match or a completed count both restart the persistence window.
      cnt_d[i] = (sync2_q[i] == sw_q[i] || upd[i]) ? '0 : cnt_q[i] + CNT_W'(1);
      sw_d[i] = upd[i] ? sync2_q[i] : sw_q[i];
    end
    // Set beats clear on a colliding edge.
    mask_d = (clr ? '0 : mask_q) | upd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      sw_q <= RESET_VAL;
      cnt_q <= '{default: '0};
      changed_q <= 1'b0;
      mask_q <= '0;
    end else begin
      sync1_q <= raw_sw;
      sync2_q <= sync1_q;
      sw_q <= sw_d;
      cnt_q <= cnt_d;
      changed_q <= |upd;
      mask_q <= mask_d;
    end
  end
  assign sw_out = sw_q;
  assign changed = changed_q;
  assign change_mask = mask_q;
endmodule
